// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
//
// Purpose: parity selection enum, receiver state enum, oversampling constant
//          and the 2-of-3 majority helper used for bit decisions.
// Ports:   none (package).

package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversampling tick generator with phase restart
//
// Purpose: emits a one-cycle tick every DIV clocks; restart re-phases the
//          divider so the first tick lands DIV clocks after the restart.
// Ports:   clk     - clock
//          n_rst   - asynchronous active-low reset
//          restart - clears the divider (start edge seen)
//          o_tick  - one-cycle sample tick

module uart_baud_tick #(
   parameter int DIV = 27
) (
   input  logic clk,
   input  logic n_rst,
   input  logic restart,
   output logic o_tick
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt    <= '0;
         o_tick <= 1'b0;
      end else if (restart) begin
         cnt    <= '0;
         o_tick <= 1'b0;
      end else if (cnt == CW'(DIV - 1)) begin
         cnt    <= '0;
         o_tick <= 1'b1;
      end else begin
         cnt    <= cnt + CW'(1);
         o_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - 16x oversampling UART receiver with error flags
//
// Purpose: synchronises the serial line, frames characters with majority
//          voting at ticks 7/8/9, and reports data plus parity, framing and
//          break status on a one-cycle strobe.
// Ports:   clk             - clock
//          n_rst           - asynchronous active-low reset
//          i_rx            - asynchronous serial input, idle high
//          o_data          - received character (LSB first on the line)
//          o_data_valid    - one-cycle strobe qualifying data and flags
//          o_parity_error  - parity mismatch on the strobed frame
//          o_framing_error - a stop bit sampled low
//          o_break         - framing error with all data and parity bits zero

module uart_rx_sampler #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY     = 0
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_data_valid,
   output logic                 o_parity_error,
   output logic                 o_framing_error,
   output logic                 o_break
);

   import uart_pkg::*;

   localparam int      DIV      = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam parity_e PAR_MODE = parity_e'(PARITY);

   logic                 rx_meta;
   logic                 rx_sync;
   rx_state_e            state;
   logic [3:0]           tick_idx;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 s7;
   logic                 s8;
   logic                 par_bit;
   logic                 stop_cnt;
   logic                 fe_acc;
   logic                 break_hold;
   logic                 tick;
   logic                 restart;
   logic                 bit_val;
   logic                 par_err;
   logic                 fe_now;
   logic                 brk_now;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
      end
   end

   // Start edge re-phases the divider; suppressed while waiting out a break.
   assign restart = (state == ST_IDLE) && !rx_sync && !break_hold;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk     (clk),
      .n_rst   (n_rst),
      .restart (restart),
      .o_tick  (tick)
   );

   // Tick 7 and 8 samples are held; tick 9 uses the live synchronised value.
   assign bit_val = maj3(s7, s8, rx_sync);
   assign fe_now  = fe_acc | ~bit_val;
   assign brk_now = fe_now && (shreg == '0) && !par_bit;

   always_comb begin
      par_err = 1'b0;
      if (PAR_MODE != PAR_NONE)
         par_err = (^{shreg, par_bit}) != (PAR_MODE == PAR_ODD);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state           <= ST_IDLE;
         tick_idx        <= '0;
         bit_cnt         <= '0;
         shreg           <= '0;
         s7              <= 1'b1;
         s8              <= 1'b1;
         par_bit         <= 1'b0;
         stop_cnt        <= 1'b0;
         fe_acc          <= 1'b0;
         break_hold      <= 1'b0;
         o_data          <= '0;
         o_data_valid    <= 1'b0;
         o_parity_error  <= 1'b0;
         o_framing_error <= 1'b0;
         o_break         <= 1'b0;
      end else begin
         o_data_valid <= 1'b0;
         if (state == ST_IDLE) begin
            // A break leaves the line low; wait for idle so one long break
            // produces a single strobe instead of a stream of them.
            if (break_hold) begin
               if (rx_sync)
                  break_hold <= 1'b0;
            end else if (!rx_sync) begin
               state    <= ST_START;
               tick_idx <= '0;
            end
         end else if (tick) begin
            tick_idx <= tick_idx + 4'd1;
            if (tick_idx == 4'd7)
               s7 <= rx_sync;
            if (tick_idx == 4'd8)
               s8 <= rx_sync;
            case (state)
               ST_START: begin
                  if (tick_idx == 4'd9 && bit_val) begin
                     state <= ST_IDLE;
                  end else if (tick_idx == 4'd15) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                  end
               end
               ST_DATA: begin
                  if (tick_idx == 4'd9)
                     shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                  if (tick_idx == 4'd15) begin
                     if (bit_cnt == 4'(DATA_BITS - 1)) begin
                        state    <= (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                        stop_cnt <= 1'b0;
                        fe_acc   <= 1'b0;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               ST_PARITY: begin
                  if (tick_idx == 4'd9)
                     par_bit <= bit_val;
                  if (tick_idx == 4'd15)
                     state <= ST_STOP;
               end
               ST_STOP: begin
                  if (tick_idx == 4'd9) begin
                     if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        // Report mid-stop-bit and go straight back to idle so
                        // a following start edge is not missed.
                        o_data          <= shreg;
                        o_parity_error  <= par_err;
                        o_framing_error <= fe_now;
                        o_break         <= brk_now;
                        o_data_valid    <= 1'b1;
                        break_hold      <= brk_now;
                        state           <= ST_IDLE;
                     end else begin
                        fe_acc <= fe_now;
                     end
                  end
                  if (tick_idx == 4'd15)
                     stop_cnt <= 1'b1;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - self-checking bench for uart_rx_sampler

module tb_uart_rx_sampler;

   localparam int CLK_FREQ = 50000000;
   localparam int BAUD     = 115200;
   localparam int BIT_CLKS = (CLK_FREQ / (BAUD * 16)) * 16;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       rx_n;
   logic       rx_e;
   logic [7:0] d_n, d_e;
   logic       v_n, pe_n, fe_n, brk_n;
   logic       v_e, pe_e, fe_e, brk_e;

   int checks   = 0;
   int failures = 0;

   logic [10:0] cap_n[$];
   logic [10:0] cap_e[$];

   always #5 clk = ~clk;

   uart_rx_sampler #(
      .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
      .DATA_BITS(8), .STOP_BITS(1), .PARITY(0)
   ) dut_n (
      .clk(clk), .n_rst(n_rst), .i_rx(rx_n), .o_data(d_n), .o_data_valid(v_n),
      .o_parity_error(pe_n), .o_framing_error(fe_n), .o_break(brk_n)
   );

   uart_rx_sampler #(
      .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
      .DATA_BITS(8), .STOP_BITS(1), .PARITY(2)
   ) dut_e (
      .clk(clk), .n_rst(n_rst), .i_rx(rx_e), .o_data(d_e), .o_data_valid(v_e),
      .o_parity_error(pe_e), .o_framing_error(fe_e), .o_break(brk_e)
   );

   always @(negedge clk) begin
      if (v_n) cap_n.push_back({brk_n, fe_n, pe_n, d_n});
      if (v_e) cap_e.push_back({brk_e, fe_e, pe_e, d_e});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected record {break, framing, parity_error, data} from the frame rules.
   function automatic logic [10:0] model(input logic [7:0] d, input logic has_par,
                                         input logic odd, input logic pbit,
                                         input logic stopv);
      int   ones;
      logic pe, fe, brk;
      ones = $countones(d) + ((has_par && pbit) ? 1 : 0);
      pe   = has_par && ((ones % 2 == 1) != odd);
      fe   = !stopv;
      brk  = fe && (d == 8'h00) && !(has_par && pbit);
      return {brk, fe, pe, d};
   endfunction

   task automatic drive(input int ch, input logic v, input int clks);
      @(negedge clk);
      if (ch == 0) rx_n = v; else rx_e = v;
      repeat (clks - 1) @(negedge clk);
   endtask

   task automatic send_frame(input int ch, input logic [7:0] d, input logic has_par,
                             input logic pbit, input logic stopv);
      drive(ch, 1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) drive(ch, d[i], BIT_CLKS);
      if (has_par) drive(ch, pbit, BIT_CLKS);
      drive(ch, stopv, BIT_CLKS);
   endtask

   task automatic expect_frame(input int ch, input string tag, input logic [10:0] exp);
      int          n;
      logic [10:0] got;
      n = (ch == 0) ? cap_n.size() : cap_e.size();
      chk({tag, "_strobe"}, 32'(n != 0), 32'd1);
      if (n != 0) begin
         got = (ch == 0) ? cap_n.pop_front() : cap_e.pop_front();
         chk(tag, 32'(got), 32'(exp));
      end
   endtask

   task automatic expect_count(input int ch, input string tag, input int n);
      chk(tag, 32'((ch == 0) ? cap_n.size() : cap_e.size()), 32'(n));
   endtask

   initial begin
      logic [10:0] exp_q[$];
      logic [10:0] exp_e[$];
      logic [7:0]  d;
      logic        s, p;
      int          gap;

      n_rst = 1'b0;
      rx_n  = 1'b1;
      rx_e  = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_data", 32'(d_n), 32'h0);
      chk("rst_valid", 32'(v_n), 32'h0);
      chk("rst_flags", 32'({pe_n, fe_n, brk_n}), 32'h0);
      chk("rst_data_e", 32'({d_e, v_e, pe_e, fe_e, brk_e}), 32'h0);
      n_rst = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);

      fork
         begin
            send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
            drive(0, 1'b1, BIT_CLKS);
            expect_frame(0, "f55", model(8'h55, 0, 0, 0, 1));
            expect_count(0, "f55_once", 0);

            send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
            drive(0, 1'b1, BIT_CLKS);
            expect_frame(0, "frm3c", model(8'h3C, 0, 0, 0, 0));
            expect_count(0, "frm3c_once", 0);

            send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
            send_frame(0, 8'h34, 1'b0, 1'b0, 1'b1);
            drive(0, 1'b1, BIT_CLKS);
            expect_frame(0, "b2b_12", model(8'h12, 0, 0, 0, 1));
            expect_frame(0, "b2b_34", model(8'h34, 0, 0, 0, 1));

            drive(0, 1'b0, 150);
            drive(0, 1'b1, 2 * BIT_CLKS);
            expect_count(0, "glitch_none", 0);
            send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
            drive(0, 1'b1, BIT_CLKS);
            expect_frame(0, "after_glitch", model(8'h5A, 0, 0, 0, 1));

            drive(0, 1'b0, 20 * BIT_CLKS);
            expect_frame(0, "break", model(8'h00, 0, 0, 0, 0));
            expect_count(0, "break_once", 0);
            drive(0, 1'b1, BIT_CLKS);
            expect_count(0, "break_rise", 0);
            send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1);
            drive(0, 1'b1, BIT_CLKS);
            expect_frame(0, "after_break", model(8'hC3, 0, 0, 0, 1));

            for (int i = 0; i < 4; i++) begin
               d   = 8'($urandom);
               s   = ($urandom_range(0, 3) != 0);
               gap = s ? $urandom_range(0, 1) : 1;
               send_frame(0, d, 1'b0, 1'b0, s);
               exp_q.push_back(model(d, 0, 0, 0, s));
               if (gap != 0) drive(0, 1'b1, gap * BIT_CLKS);
            end
            drive(0, 1'b1, BIT_CLKS);
            expect_count(0, "rand_n_count", exp_q.size());
            while (exp_q.size() != 0) expect_frame(0, "rand_n", exp_q.pop_front());
         end
         begin
            send_frame(1, 8'hA7, 1'b1, 1'b1, 1'b1);
            drive(1, 1'b1, BIT_CLKS);
            expect_frame(1, "a7_p1", model(8'hA7, 1, 0, 1, 1));
            send_frame(1, 8'hA7, 1'b1, 1'b0, 1'b1);
            drive(1, 1'b1, BIT_CLKS);
            expect_frame(1, "a7_p0", model(8'hA7, 1, 0, 0, 1));

            for (int i = 0; i < 4; i++) begin
               d   = 8'($urandom);
               p   = 1'($urandom);
               gap = $urandom_range(0, 1);
               send_frame(1, d, 1'b1, p, 1'b1);
               exp_e.push_back(model(d, 1, 0, p, 1));
               if (gap != 0) drive(1, 1'b1, gap * BIT_CLKS);
            end
            drive(1, 1'b1, BIT_CLKS);
            expect_count(1, "rand_e_count", exp_e.size());
            while (exp_e.size() != 0) expect_frame(1, "rand_e", exp_e.pop_front());
         end
      join

      send_frame(0, 8'hE7, 1'b0, 1'b0, 1'b1);
      drive(0, 1'b1, BIT_CLKS);
      expect_frame(0, "pre_rst", model(8'hE7, 0, 0, 0, 1));
      drive(0, 1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) drive(0, i[0], BIT_CLKS);
      drive(0, 1'b1, 200);
      n_rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("midrst_data", 32'(d_n), 32'h0);
      chk("midrst_flags", 32'({v_n, pe_n, fe_n, brk_n}), 32'h0);
      rx_n  = 1'b1;
      n_rst = 1'b1;
      repeat (3 * BIT_CLKS) @(negedge clk);
      expect_count(0, "midrst_none", 0);
      send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
      drive(0, 1'b1, BIT_CLKS);
      expect_frame(0, "post_rst_81", model(8'h81, 0, 0, 0, 1));
      expect_count(0, "post_rst_once", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
